// File: rtl/halut_pkg.sv
// Shared types and default widths for the HALUT accumulator slice.
package halut_pkg;

    localparam int IN_WIDTH_DEF  = 8;
    localparam int OUT_WIDTH_DEF = 32;
    localparam int NUM_TERMS_DEF = 32;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_e;

endpackage

// File: rtl/mixed_int_adder.sv
// Sign-extends a narrow signed term and adds it to a wide signed accumulator,
// wrapping modulo 2^OUT_WIDTH.
module mixed_int_adder #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic [OUT_WIDTH-1:0] acc_i,
    input  logic [IN_WIDTH-1:0]  term_i,
    output logic [OUT_WIDTH-1:0] sum_o
);

    logic [OUT_WIDTH-1:0] term_ext;

    assign term_ext = {{(OUT_WIDTH-IN_WIDTH){term_i[IN_WIDTH-1]}}, term_i};
    assign sum_o    = acc_i + term_ext;

endmodule

// File: rtl/halut_accumulator.sv
// Sums NUM_TERMS signed LUT entries per result behind valid/ready handshakes.
// Define HALUT_ACC_SAT_EN for saturating adds with a sticky overflow_o flag.
module halut_accumulator
    import halut_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int NUM_TERMS = NUM_TERMS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam int                CNT_W = (NUM_TERMS > 2) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_TERMS - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [OUT_WIDTH-1:0] sum_wrap;
    logic [OUT_WIDTH-1:0] add_res;
    logic                 in_xfer;

    mixed_int_adder #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_adder (
        .acc_i  (acc_q),
        .term_i (in_data_i),
        .sum_o  (sum_wrap)
    );

`ifdef HALUT_ACC_SAT_EN
    logic add_ovf;
    logic ovf_acc_q, ovf_acc_d;
    logic ovf_out_q, ovf_out_d;

    // Signed overflow: operands share a sign that the wrapped sum does not.
    assign add_ovf = (acc_q[OUT_WIDTH-1] == in_data_i[IN_WIDTH-1]) &&
                     (sum_wrap[OUT_WIDTH-1] != acc_q[OUT_WIDTH-1]);
    assign add_res = !add_ovf ? sum_wrap :
                     acc_q[OUT_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    assign overflow_o = ovf_out_q;
`else
    assign add_res    = sum_wrap;
    assign overflow_o = 1'b0;
`endif

    assign in_xfer     = in_valid_i && (state_q == ACCUM);
    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == OUTPUT);
    assign out_data_o  = out_data_q;
    assign busy_o      = (cnt_q != '0) || (state_q == OUTPUT);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
`ifdef HALUT_ACC_SAT_EN
        ovf_acc_d  = ovf_acc_q;
        ovf_out_d  = ovf_out_q;
`endif
        if (clear_i) begin
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
`ifdef HALUT_ACC_SAT_EN
            ovf_acc_d = 1'b0;
            ovf_out_d = 1'b0;
`endif
        end else if (state_q == ACCUM) begin
            if (in_xfer) begin
                if (cnt_q == LAST) begin
                    out_data_d = add_res;
                    cnt_d      = '0;
                    acc_d      = '0;
                    state_d    = OUTPUT;
`ifdef HALUT_ACC_SAT_EN
                    ovf_out_d = ovf_acc_q | add_ovf;
                    ovf_acc_d = 1'b0;
`endif
                end else begin
                    acc_d = add_res;
                    cnt_d = cnt_q + 1'b1;
`ifdef HALUT_ACC_SAT_EN
                    ovf_acc_d = ovf_acc_q | add_ovf;
`endif
                end
            end
        end else if (out_ready_i) begin
            state_d = ACCUM;
`ifdef HALUT_ACC_SAT_EN
            ovf_out_d = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
`ifdef HALUT_ACC_SAT_EN
            ovf_acc_q  <= 1'b0;
            ovf_out_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
`ifdef HALUT_ACC_SAT_EN
            ovf_acc_q  <= ovf_acc_d;
            ovf_out_q  <= ovf_out_d;
`endif
        end
    end

endmodule

// File: tb/tb_halut_accumulator.sv
// Directed bench for halut_accumulator: a 32-bit/4-term instance and a
// 10-bit/8-term instance, with a result scoreboard per instance.
module tb_halut_accumulator;

    logic clk = 1'b0;
    logic rst;

    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_overflow;
    logic [7:0]  a_in_data;
    logic [31:0] a_out_data;

    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_overflow;
    logic [7:0]  b_in_data;
    logic [9:0]  b_out_data;

    int vectors = 0;
    int fails   = 0;

    logic [31:0] sb_a[$];
    logic [31:0] sb_b[$];
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_b_ovf;

    always #5 clk = ~clk;

    halut_accumulator #(.IN_WIDTH(8), .OUT_WIDTH(32), .NUM_TERMS(4)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (a_clear),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .in_data_i   (a_in_data),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_data_o  (a_out_data),
        .busy_o      (a_busy),
        .overflow_o  (a_overflow)
    );

    halut_accumulator #(.IN_WIDTH(8), .OUT_WIDTH(10), .NUM_TERMS(8)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (b_clear),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   (b_in_data),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_data_o  (b_out_data),
        .busy_o      (b_busy),
        .overflow_o  (b_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic a_send(input logic [7:0] v);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = v;
    endtask

    // Closes a back-to-back burst: result must be valid one cycle after the last transfer.
    task automatic a_end_sum(input string tag);
        @(negedge clk);
        check({tag, "_latency"}, a_out_valid, 1'b1);
        a_in_valid = 1'b0;
    endtask

    task automatic a_wait_valid(input string tag);
        int n = 0;
        while (!a_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_seen"}, a_out_valid, 1'b1);
    endtask

    task automatic a_drain(input string tag);
        exp_a = sb_a.pop_front();
        check({tag, "_data"}, a_out_data, exp_a);
        check({tag, "_ovf"}, a_overflow, 1'b0);
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check({tag, "_ready_after_hs"}, a_in_ready, 1'b1);
        check({tag, "_valid_after_hs"}, a_out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        {a_clear, a_in_valid, a_out_ready, a_in_data} = '0;
        {b_clear, b_in_valid, b_out_ready, b_in_data} = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_in_ready", a_in_ready, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_overflow", a_overflow, 1'b0);
        check("rst_out_data", a_out_data, 32'd0);
        rst = 1'b0;

        // 1+2+3+4 back-to-back
        a_send(8'd1);
        a_send(8'd2);
        a_send(8'd3);
        a_send(8'd4);
        sb_a.push_back(32'd10);
        a_end_sum("sum10");
        a_drain("sum10");

        // Four -128, busy from first transfer, then hold output 5 cycles with valid input
        a_send(8'h80);
        a_send(8'h80);
        check("busy_after_1st", a_busy, 1'b1);
        a_send(8'h80);
        check("busy_after_2nd", a_busy, 1'b1);
        a_send(8'h80);
        check("busy_after_3rd", a_busy, 1'b1);
        sb_a.push_back(32'hFFFF_FE00);
        @(negedge clk);
        check("neg_latency", a_out_valid, 1'b1);
        a_in_data = 8'd5;
        exp_a = sb_a.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("hold_data", a_out_data, exp_a);
            check("hold_in_ready", a_in_ready, 1'b0);
            check("hold_busy", a_busy, 1'b1);
            @(negedge clk);
        end
        check("hold_data_end", a_out_data, exp_a);
        a_out_ready = 1'b1;
        @(negedge clk);
        check("hs_in_ready", a_in_ready, 1'b1);
        check("hs_out_valid", a_out_valid, 1'b0);
        check("hs_no_term_taken", a_busy, 1'b0);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;

        // Clear after two terms; term presented with clear is discarded
        a_send(8'd7);
        a_send(8'd9);
        @(negedge clk);
        a_clear   = 1'b1;
        a_in_data = 8'd100;
        @(negedge clk);
        a_clear    = 1'b0;
        a_in_valid = 1'b0;
        check("clear_busy", a_busy, 1'b0);
        for (int i = 0; i < 4; i++) a_send(8'd1);
        sb_a.push_back(32'd4);
        a_end_sum("after_clear");
        a_drain("after_clear");

        // Gaps in in_valid_i: 5 + (-3) + 7 + (-1) = 8
        a_send(8'd5);
        @(negedge clk) a_in_valid = 1'b0;
        @(negedge clk);
        a_send(8'hFD);
        a_send(8'd7);
        @(negedge clk) a_in_valid = 1'b0;
        check("gap_busy", a_busy, 1'b1);
        check("gap_no_result", a_out_valid, 1'b0);
        a_send(8'hFF);
        sb_a.push_back(32'd8);
        @(negedge clk) a_in_valid = 1'b0;
        a_wait_valid("gap");
        a_drain("gap");

        // Reset during OUTPUT discards the pending result
        for (int i = 0; i < 4; i++) a_send(8'd50);
        a_end_sum("pre_rst");
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", a_out_valid, 1'b0);
        check("rst_mid_in_ready", a_in_ready, 1'b1);
        check("rst_mid_busy", a_busy, 1'b0);
        check("rst_mid_data", a_out_data, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_stale", a_out_valid, 1'b0);
        for (int i = 0; i < 4; i++) a_send(8'd2);
        sb_a.push_back(32'd8);
        a_end_sum("post_rst");
        a_drain("post_rst");

        // Narrow accumulator: eight terms of 127
`ifdef HALUT_ACC_SAT_EN
        sb_b.push_back(32'd511);
        exp_b_ovf = 1'b1;
`else
        sb_b.push_back(32'h3F8);
        exp_b_ovf = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_data  = 8'd127;
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        exp_b = sb_b.pop_front();
        check("b_valid", b_out_valid, 1'b1);
        check("b_data", b_out_data, exp_b);
        check("b_ovf", b_overflow, exp_b_ovf);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("b_ovf_after_hs", b_overflow, 1'b0);
        check("b_valid_after_hs", b_out_valid, 1'b0);

        check("scoreboard_empty", 64'(sb_a.size() + sb_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/halut_accumulator.md
HALUT_ACCUMULATOR -- requirements
Module: halut_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, meaning signed LUT-entry width.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, meaning signed accumulator/result width; OUT_WIDTH > IN_WIDTH.
REQ-003 SHALL have parameter NUM_TERMS, default 32, meaning terms (codebooks) summed per result; range 2..1024.
REQ-004 SHALL have ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous abort of the current sum.
- in_valid_i  in  1  input term valid.
- in_ready_o  out  1  block accepts a term.
- in_data_i  in  IN_WIDTH  signed term.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- out_data_o  out  OUT_WIDTH  signed result.
- busy_o  out  1  at least one term of the current sum accepted, or result pending.
- overflow_o  out  1  result saturated (only with HALUT_ACC_SAT_EN).

Function
REQ-005 SHALL implement two states: ACCUM (in_ready_o=1, out_valid_o=0) and OUTPUT (in_ready_o=0, out_valid_o=1).
REQ-006 An input transfer SHALL occur when in_valid_i && in_ready_o; the term SHALL be sign-extended to OUT_WIDTH and added to the accumulator.
REQ-007 A term counter SHALL count from 0 to NUM_TERMS-1; on the transfer with count NUM_TERMS-1, the final sum SHALL be registered into out_data_o, the counter and accumulator SHALL go to 0, and the state SHALL go to OUTPUT.
REQ-008 Latency SHALL be 1 cycle: out_valid_o rises in the cycle after the last term transfer.
REQ-009 In OUTPUT, out_data_o SHALL hold stable until out_valid_o && out_ready_i; on that handshake the state SHALL return to ACCUM.
REQ-010 in_ready_o SHALL depend only on state, with no combinational path from any input; the block SHALL NOT accept a term in the same cycle as the output handshake.
REQ-011 Gaps in in_valid_i SHALL NOT alter the accumulator or counter.
REQ-012 Without saturation, addition SHALL wrap in two's complement modulo 2^OUT_WIDTH.
REQ-013 clear_i SHALL have priority over all transfers: next cycle state=ACCUM, counter=0, accumulator=0, out_valid_o=0, overflow_o=0; a term presented with clear_i is discarded.
REQ-014 busy_o SHALL be 1 when counter != 0 or state=OUTPUT.

Reset
REQ-015 On rst_i, asynchronously: state=ACCUM, counter=0, accumulator=0, out_data_o=0, out_valid_o=0, in_ready_o=1, busy_o=0, overflow_o=0.
REQ-016 Reset mid-sum or mid-output SHALL discard all partial and pending results.

Configuration
REQ-017 Macro HALUT_ACC_SAT_EN defined: each add SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; overflow_o SHALL be sticky across the sum and presented with the result, then cleared on the output handshake.
REQ-018 Macro undefined: wrapping per REQ-012; overflow_o SHALL be tied to 0.

Structure
REQ-019 A shared package halut_pkg SHALL hold the state enum type (ACCUM, OUTPUT) and default width constants.
REQ-020 The sign-extend-and-add SHALL be a mixed_int_adder sub-module instance in the wrapping build; the saturating build adds an overflow check around it.

Verification
REQ-021 NUM_TERMS=4, terms 1,2,3,4 back-to-back -> out_data_o=10, out_valid_o=1 exactly one cycle after the 4th transfer.
REQ-022 NUM_TERMS=4, four terms of -128 -> out_data_o=-512 (0xFFFFFE00); busy_o=1 from the 1st transfer until the handshake.
REQ-023 Hold out_ready_i=0 for 5 cycles with in_valid_i=1 -> out_data_o stable, in_ready_o=0, no term consumed; handshake -> in_ready_o=1 next cycle.
REQ-024 clear_i after 2 terms, then four terms of 1 -> result 4; rst_i pulsed during OUTPUT -> out_valid_o=0 immediately, with no result emitted.
REQ-025 OUT_WIDTH=10, NUM_TERMS=8, eight terms of 127: without macro -> -8 (wrapped 1016); with HALUT_ACC_SAT_EN -> 511, overflow_o=1, overflow_o=0 after the handshake.
